divider_datapath: RTL and testbench

//   Sequential restoring shift-subtract divider. Produces one quotient bit per clock.

---
 rtl/divider_datapath.sv | 183 ++++++++++++++++++
 tb/tb_divider_datapath.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/divider_datapath.sv
// divider_datapath: sequential restoring shift-subtract divider, one quotient
// bit per clock, with its own start/busy/done sequencing.
//
// Build option: define DIVIDER_SIGNED_EN for two's-complement operands.
// Magnitudes are taken at accept and the sign is applied when the result is
// loaded, so latency does not change. Without the macro the divider is
// unsigned only and no sign logic exists.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; busy=0
// RUN    | one shift-subtract step per cycle, WIDTH cycles in total
// FINISH | results already loaded; next edge drops busy and raises done

module divider_datapath #(
    parameter int WIDTH = 32
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_by_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t             r_state;
    logic [CW-1:0]      r_count;
    // {partial remainder, remaining dividend / growing quotient}
    logic [2*WIDTH-1:0] r_work;
    logic [WIDTH-1:0]   r_divisor;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;
    logic               r_div_by_zero;

    logic [2*WIDTH:0]   w_shift;
    logic [WIDTH:0]     w_partial;
    logic [WIDTH:0]     w_divisor_ext;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [2*WIDTH-1:0] w_next_work;
    logic [WIDTH-1:0]   w_quo_mag;
    logic [WIDTH-1:0]   w_rem_mag;
    logic [WIDTH-1:0]   w_dvd_mag;
    logic [WIDTH-1:0]   w_dvs_mag;
    logic [WIDTH-1:0]   w_quo_res;
    logic [WIDTH-1:0]   w_rem_res;
    logic               w_last_step;
    // After a restoring subtract the partial is below the divisor, so the
    // top bit of the difference is always zero and is not stored.
    logic               w_unused_diff_msb;

`ifdef DIVIDER_SIGNED_EN
    logic               r_neg_q;
    logic               r_neg_r;
    logic               w_dvd_neg;
    logic               w_dvs_neg;
`endif

    // One restoring step: shift, trial-subtract, keep or restore.
    always_comb begin
        w_shift           = {1'b0, r_work} << 1;
        w_partial         = w_shift[2*WIDTH:WIDTH];
        w_divisor_ext     = {1'b0, r_divisor};
        w_ge              = (w_partial >= w_divisor_ext);
        w_diff            = w_partial - w_divisor_ext;
        w_unused_diff_msb = w_diff[WIDTH];
        if (w_ge) begin
            w_next_work = {w_diff[WIDTH-1:0], w_shift[WIDTH-1:1], 1'b1};
        end else begin
            w_next_work = w_shift[2*WIDTH-1:0];
        end
        w_quo_mag   = w_next_work[WIDTH-1:0];
        w_rem_mag   = w_next_work[2*WIDTH-1:WIDTH];
        w_last_step = (r_count == CW'(WIDTH - 1));
    end

`ifdef DIVIDER_SIGNED_EN
    // Operand magnitudes at accept and sign restoration at result load.
    always_comb begin
        w_dvd_neg = i_dividend[WIDTH-1];
        w_dvs_neg = i_divisor[WIDTH-1];
        w_dvd_mag = w_dvd_neg ? (-i_dividend) : i_dividend;
        w_dvs_mag = w_dvs_neg ? (-i_divisor)  : i_divisor;
        w_quo_res = r_neg_q ? (-w_quo_mag) : w_quo_mag;
        w_rem_res = r_neg_r ? (-w_rem_mag) : w_rem_mag;
    end
`else
    // Unsigned build: operands and results pass straight through.
    always_comb begin
        w_dvd_mag = i_dividend;
        w_dvs_mag = i_divisor;
        w_quo_res = w_quo_mag;
        w_rem_res = w_rem_mag;
    end
`endif

    // Control FSM, iteration counter, working register and result registers.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_count       <= '0;
            r_work        <= '0;
            r_divisor     <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            r_neg_q       <= 1'b0;
            r_neg_r       <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_busy <= 1'b1;
                        if (i_divisor == '0) begin
                            // No iterations; the result is known right away.
                            r_state       <= S_FINISH;
                            r_quotient    <= '1;
                            r_remainder   <= i_dividend;
                            r_div_by_zero <= 1'b1;
                        end else begin
                            r_state   <= S_RUN;
                            r_count   <= '0;
                            r_work    <= {{WIDTH{1'b0}}, w_dvd_mag};
                            r_divisor <= w_dvs_mag;
`ifdef DIVIDER_SIGNED_EN
                            r_neg_q   <= w_dvd_neg ^ w_dvs_neg;
                            r_neg_r   <= w_dvd_neg;
`endif
                        end
                    end
                end
                S_RUN: begin
                    r_work <= w_next_work;
                    if (w_last_step) begin
                        // Results are taken from the final step's output so
                        // they land on the FINISH entry edge.
                        r_state       <= S_FINISH;
                        r_quotient    <= w_quo_res;
                        r_remainder   <= w_rem_res;
                        r_div_by_zero <= 1'b0;
                    end else begin
                        r_count <= r_count + CW'(1);
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_quotient    = r_quotient;
    assign o_remainder   = r_remainder;
    assign o_div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_divider_datapath.sv
// Scoreboard bench for divider_datapath: stimulus pushes the expected result
// and completion cycle, a monitor pops and compares on every done pulse.

module tb_divider_datapath;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dvd;
    logic [W-1:0] dvs;
    logic         busy;
    logic         done;
    logic [W-1:0] quo;
    logic [W-1:0] rem;
    logic         dz;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           due;
        string        name;
    } exp_t;

    exp_t sb[$];

    divider_datapath #(.WIDTH(W)) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_start      (start),
        .i_dividend   (dvd),
        .i_divisor    (dvs),
        .o_busy       (busy),
        .o_done       (done),
        .o_quotient   (quo),
        .o_remainder  (rem),
        .o_div_by_zero(dz)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
            end else begin
                e = sb.pop_front();
                check({e.name, "_quotient"},  quo, e.q);
                check({e.name, "_remainder"}, rem, e.r);
                check({e.name, "_dbz"},       {31'b0, dz}, {31'b0, e.dz});
                check({e.name, "_cycle"},     W'(cyc), W'(e.due));
            end
        end
    end

    // Issue one start at the current (negedge) time; accepted on the next edge.
    task automatic issue(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] q, input logic [W-1:0] r, input logic z,
                         input bit expect_done);
        exp_t e;
        dvd   = a;
        dvs   = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        dvd   = $urandom;
        dvs   = $urandom;
        if (expect_done) begin
            e.q    = q;
            e.r    = r;
            e.dz   = z;
            e.due  = cyc + (z ? 1 : W + 1);
            e.name = name;
            sb.push_back(e);
        end
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no_done required=done", name);
        end
    endtask

    task automatic run(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] q, input logic [W-1:0] r, input logic z);
        issue(name, a, b, q, r, z, 1'b1);
        wait_done(name);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_busy"}, {31'b0, busy}, 32'd0);
        check({name, "_done"}, {31'b0, done}, 32'd0);
        check({name, "_quo"},  quo, 32'd0);
        check({name, "_rem"},  rem, 32'd0);
        check({name, "_dbz"},  {31'b0, dz}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst   = 1'b1;
        start = 1'b0;
        dvd   = '0;
        dvs   = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_all_zero("reset");

        // 100/7 with busy-length measurement.
        issue("d100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done === 1'b1) break;
            if (busy === 1'b1) n++;
        end
        check("busy_cycles", W'(n), 32'd33);
        check("busy_in_done_cycle", {31'b0, busy}, 32'd0);

        // Back-to-back starts, each issued in the previous done cycle.
        run("dmax_1",  32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
        run("d5_9",    32'd5, 32'd9, 32'd0, 32'd5, 1'b0);
        run("d1234_0", 32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1'b1);
        run("d0_5",    32'd0, 32'd5, 32'd0, 32'd0, 1'b0);
        run("dmax_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
`ifndef DIVIDER_SIGNED_EN
        run("dmin_3",   32'h8000_0000, 32'd3, 32'd715827882, 32'd2, 1'b0);
        run("d12345678_256", 32'd12345678, 32'd256, 32'd48225, 32'd78, 1'b0);
        run("d1000000_1000", 32'd1000000, 32'd1000, 32'd1000, 32'd0, 1'b0);
`else
        run("sm7_2",    32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        run("s7_m2",    32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
        run("smin_m1",  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
        run("sm8_0",    32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF8, 1'b1);
`endif

        // Results hold after done.
        run("d100_7_hold", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        repeat (5) @(negedge clk);
        check("hold_quotient",  quo, 32'd14);
        check("hold_remainder", rem, 32'd2);

        // Start while busy is ignored; the monitor checks the original timing.
        issue("d100_7_ign", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);
        repeat (9) @(negedge clk);
        dvd   = 32'd50;
        dvs   = 32'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("d100_7_ign");

        // Reset mid-run: no done for the aborted division, outputs cleared.
        @(negedge clk);
        issue("d100_7_abort", 32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("abort");
        repeat (40) @(negedge clk);
        run("d9_3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

        // Reset wins over start in the same cycle.
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        dvd   = 32'd9;
        dvs   = 32'd3;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check_all_zero("rst_vs_start");
        repeat (40) @(negedge clk);

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL pending_results actual=%0d required=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
